// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 receive front end in the system clock domain.
// The raw keyboard clock and data lines are synchronized and deglitched.
// Falling edges of the filtered clock drive an 11-bit frame FSM.
// E0/F0 prefix bytes are folded into ext/brk flags, and one scan code per
// keystroke is presented on a valid/ready handshake.
//
// Optional feature macro: PS2_PARITY_CHECK_EN. When defined, odd parity is
// enforced. When undefined, the parity bit is clocked through and ignored.
//
// Ports:
//   c      in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   ps2c   in   raw keyboard clock (asynchronous)
//   ps2d   in   raw keyboard data (asynchronous)
//   code   out  scan code byte, prefixes stripped
//   ext    out  an E0 prefix preceded code
//   brk    out  an F0 prefix preceded code (key release)
//   valid  out  code/ext/brk are valid
//   ready  in   consumer accepts on valid && ready
//   err    out  one-cycle pulse on framing/parity/timeout/overflow error
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       c,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk,
    output logic       valid,
    input  logic       ready,
    output logic       err
);

    localparam int unsigned FCW = $clog2(FILTER_LEN);
    localparam int unsigned WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Index 0 carries the keyboard clock, index 1 the keyboard data.
    logic [1:0]     sync_a;
    logic [1:0]     sync_b;
    logic [1:0]     filt;
    logic [FCW-1:0] fcnt [2];
    logic           clk_prev;

    logic           fall_c;
    logic           bit_c;
    logic           timeout_c;
    logic           parity_ok_c;

    state_t         state;
    state_t         state_n;

    logic           shift_c;
    logic           cnt_clr_c;
    logic           par_cap_c;
    logic           good_c;
    logic           frame_err_c;

    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [WDW-1:0] wd;

    logic           pend_ext;
    logic           pend_brk;

    logic           is_e0_c;
    logic           is_f0_c;
    logic           emit_c;
    logic           load_c;
    logic           overflow_c;

    // Two-flop synchronizers followed by saturating-count deglitch filters.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sync_a  <= 2'b11;
            sync_b  <= 2'b11;
            filt    <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync_a <= {ps2d, ps2c};
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != filt[i]) begin
                    // The FILTER_LEN-th consecutive differing sample flips the line.
                    if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                        filt[i] <= sync_b[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + FCW'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // Previous filtered clock value for falling-edge detection.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= filt[0];
        end
    end

    assign fall_c = clk_prev & ~filt[0];
    assign bit_c  = filt[1];

    // A fall in the same cycle restarts the watchdog instead of expiring it.
    assign timeout_c = (state != ST_IDLE) && !fall_c && (wd == WDW'(TIMEOUT - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    // Parity bit capture, used only when parity is enforced.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (par_cap_c) begin
            par_q <= bit_c;
        end
    end

    // Odd parity: data bits plus parity bit hold an odd number of ones.
    assign parity_ok_c = ^{shreg, par_q};
`else
    assign parity_ok_c = 1'b1;
`endif

    // Frame FSM state register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame FSM next state; the watchdog overrides any transition.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (fall_c && !bit_c) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_c && (bit_cnt == 3'd7)) begin
                    state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall_c) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_c) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (timeout_c) begin
            state_n = ST_IDLE;
        end
    end

    // Frame FSM datapath controls.
    always_comb begin
        shift_c     = 1'b0;
        cnt_clr_c   = 1'b0;
        par_cap_c   = 1'b0;
        good_c      = 1'b0;
        frame_err_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall_c) begin
                    if (!bit_c) begin
                        cnt_clr_c = 1'b1;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                shift_c = fall_c;
            end
            ST_PARITY: begin
                par_cap_c = fall_c;
            end
            ST_STOP: begin
                if (fall_c) begin
                    if (bit_c && parity_ok_c) begin
                        good_c = 1'b1;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bit counter and LSB-first shift register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (cnt_clr_c) begin
                bit_cnt <= 3'd0;
            end else if (shift_c) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_c) begin
                shreg <= {bit_c, shreg[7:1]};
            end
        end
    end

    // Watchdog: held clear in IDLE, cleared by every filtered falling edge.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (fall_c || (state == ST_IDLE)) begin
            wd <= '0;
        end else begin
            wd <= wd + WDW'(1);
        end
    end

    assign is_e0_c    = (shreg == 8'hE0);
    assign is_f0_c    = (shreg == 8'hF0);
    assign emit_c     = good_c && !is_e0_c && !is_f0_c;
    assign load_c     = emit_c && (!valid || ready);
    assign overflow_c = emit_c && valid && !ready;

    // Prefix folding, output holding register and error pulse.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
            code     <= 8'h00;
            ext      <= 1'b0;
            brk      <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= frame_err_c | timeout_c | overflow_c;

            if (good_c && is_e0_c) begin
                pend_ext <= 1'b1;
            end else if (good_c && is_f0_c) begin
                pend_brk <= 1'b1;
            end else if (emit_c) begin
                // Flags are consumed whether the code is presented or dropped.
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
            end

            if (load_c) begin
                code  <= shreg;
                ext   <= pend_ext;
                brk   <= pend_brk;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed testbench for ps2_frame_rx with FILTER_LEN=4, TIMEOUT=200.
module tb_ps2_frame_rx;

    localparam int unsigned FL = 4;
    localparam int unsigned TO = 200;

    logic       c     = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       valid;
    logic       err;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .c     (c),
        .rst_n (rst_n),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .code  (code),
        .ext   (ext),
        .brk   (brk),
        .valid (valid),
        .ready (ready),
        .err   (err)
    );

    always #5 c = ~c;

    int n_chk = 0;
    int n_pass = 0;

    int acc_cnt = 0;
    int err_cnt = 0;
    int vcyc = 0;
    logic [9:0] last = 10'h000;

    int a0;
    int e0;
    int v0;

    // Acceptance, error and valid-cycle monitor sampled on the falling edge.
    always @(negedge c) begin
        if (rst_n) begin
            if (valid && ready) begin
                acc_cnt = acc_cnt + 1;
                last = {ext, brk, code};
            end
            if (err) begin
                err_cnt = err_cnt + 1;
            end
            if (valid) begin
                vcyc = vcyc + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge c);
        #1;
    endtask

    // One PS/2 bit: data set while clock is high, falling edge mid-period.
    task automatic send_bit(input logic b, input logic glitch);
        ps2d = b;
        if (glitch) begin
            wait_cyc(2);
            ps2c = 1'b0;
            wait_cyc(int'(FL) - 1);
            ps2c = 1'b1;
            wait_cyc(5);
        end else begin
            wait_cyc(10);
        end
        ps2c = 1'b0;
        wait_cyc(20);
        ps2c = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic glitch);
        logic par;
        par = ~(^b) ^ flip_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i], glitch);
        end
        send_bit(par, glitch);
        send_bit(1'b1, glitch);
        ps2d = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(1'b1, 1'b0);
        end
        ps2d = 1'b1;
    endtask

    task automatic snap();
        a0 = acc_cnt;
        e0 = err_cnt;
        v0 = vcyc;
    endtask

    initial begin
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);

        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(code), 32'h00);
        chk("rst_ext", 32'(ext), 32'd0);
        chk("rst_brk", 32'(brk), 32'd0);

        // Plain make code with a ready consumer.
        ready = 1'b1;
        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("f1c_acc", 32'(acc_cnt - a0), 32'd1);
        chk("f1c_word", 32'(last), 32'h01C);
        chk("f1c_vcyc", 32'(vcyc - v0), 32'd1);
        chk("f1c_err", 32'(err_cnt - e0), 32'd0);

        // Extended break sequence E0 F0 74, then plain 1C.
        snap();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        chk("e0f0_acc", 32'(acc_cnt - a0), 32'd1);
        chk("e0f0_word", 32'(last), 32'h374);
        chk("e0f0_err", 32'(err_cnt - e0), 32'd0);
        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("post_acc", 32'(acc_cnt - a0), 32'd1);
        chk("post_word", 32'(last), 32'h01C);

        // Wrong parity bit.
        snap();
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_acc", 32'(acc_cnt - a0), 32'd0);
        chk("par_err", 32'(err_cnt - e0), 32'd1);
`else
        chk("par_acc", 32'(acc_cnt - a0), 32'd1);
        chk("par_word", 32'(last), 32'h01C);
        chk("par_err", 32'(err_cnt - e0), 32'd0);
`endif

        // Overflow: second code arrives while the first is still held.
        ready = 1'b0;
        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("ovf_valid1", 32'(valid), 32'd1);
        chk("ovf_code1", 32'(code), 32'h1C);
        send_frame(8'h32, 1'b0, 1'b0);
        chk("ovf_valid2", 32'(valid), 32'd1);
        chk("ovf_code2", 32'(code), 32'h1C);
        chk("ovf_err", 32'(err_cnt - e0), 32'd1);
        chk("ovf_acc0", 32'(acc_cnt - a0), 32'd0);
        ready = 1'b1;
        wait_cyc(5);
        chk("ovf_acc1", 32'(acc_cnt - a0), 32'd1);
        chk("ovf_word", 32'(last), 32'h01C);
        chk("ovf_drop", 32'(valid), 32'd0);
        wait_cyc(100);
        chk("ovf_no32", 32'(acc_cnt - a0), 32'd1);

        // Watchdog abandons a partial frame.
        snap();
        send_partial(4);
        wait_cyc(300);
        chk("to_err", 32'(err_cnt - e0), 32'd1);
        chk("to_acc", 32'(acc_cnt - a0), 32'd0);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("to_acc29", 32'(acc_cnt - a0), 32'd1);
        chk("to_word", 32'(last), 32'h029);
        chk("to_err2", 32'(err_cnt - e0), 32'd1);

        // Short clock glitches inside every bit must not add bits.
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("gl_acc", 32'(acc_cnt - a0), 32'd1);
        chk("gl_word", 32'(last), 32'h01C);
        chk("gl_err", 32'(err_cnt - e0), 32'd0);

        // Reset mid-frame with a held code and a pending E0.
        ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        chk("mr_pre_valid", 32'(valid), 32'd1);
        send_partial(3);
        rst_n = 1'b0;
        wait_cyc(1);
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_code", 32'(code), 32'h00);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_ext", 32'(ext), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        ready = 1'b1;
        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("mr_acc", 32'(acc_cnt - a0), 32'd1);
        chk("mr_word", 32'(last), 32'h01C);
        chk("mr_err2", 32'(err_cnt - e0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 receive front end running in the system clock domain. It synchronizes and deglitches the raw keyboard clock and data lines, then detects falling edges and assembles 11-bit frames. It checks the frame, folds the E0/F0 prefix bytes into flags, and presents one make/break scan code per keystroke on a valid/ready handshake. It feeds the keystroke decode and display logic and replaces direct sampling of the keyboard clock as a register clock.

## Interface
- FILTER_LEN, 8: number of consecutive identical samples required before a filtered line changes (range 2–255).
- TIMEOUT, 50000: system cycles without a filtered falling edge before a partial frame is abandoned (range 16–2^20).
- C  in  1  system clock; all state is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PS2C  in  1  raw keyboard clock, asynchronous to C.
- PS2D  in  1  raw keyboard data, asynchronous to C.
- CODE  out  8  scan code byte (prefixes stripped); reset 8'h00.
- EXT  out  1  an E0 prefix preceded CODE; reset 0.
- BRK  out  1  an F0 prefix preceded CODE (key release); reset 0.
- VALID  out  1  CODE/EXT/BRK are valid; reset 0.
- READY  in  1  consumer accepts when VALID&&READY at a rising edge of C.
- ERR  out  1  one-cycle pulse on a framing, parity, timeout or overflow error; reset 0.

## Operation
- Input conditioning: PS2C and PS2D each pass through a 2-FF synchronizer, reset value 1.
  - Each line then goes through a saturating counter filter. The filtered value flips only after FILTER_LEN consecutive samples differ from it.
  - Filtered values reset to 1.
  - A falling edge is filtered PS2C going 1->0. At that edge, filtered PS2D is sampled.
- Frame FSM states:
  - IDLE: on an edge with data 0 (start bit), go to DATA with the bit counter at 0. An edge with data 1 is a framing error: stay in IDLE and pulse ERR.
  - DATA: shift data LSB-first into an 8-bit register. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: data 1 plus a parity pass means the byte is good. Otherwise pulse ERR. Either way, return to IDLE.
- Watchdog: a counter clears on every filtered falling edge and runs while the FSM is not in IDLE. When it reaches TIMEOUT-1, the FSM returns to IDLE, the byte is discarded and ERR pulses.
- Byte handling:
  - E0 sets the pending ext flag and F0 sets the pending brk flag; neither is emitted.
  - Any other good byte loads CODE, EXT and BRK (from the pending flags) and sets VALID. Both pending flags then clear.
  - Error frames leave the pending flags unchanged.
- Handshake:
  - VALID stays high with CODE, EXT and BRK stable until VALID&&READY, then drops the next cycle.
  - Suppose a new code completes in the same cycle as the acceptance. The output reloads and VALID stays 1.
  - Suppose a new code completes while VALID=1 and READY=0. The new code is dropped, ERR pulses, and the pending flags clear.
- Reset asserted mid-frame immediately clears the FSM, counters, pending flags and all outputs to their reset values.

## Timing
- Raw PS2C fall to filtered edge: 2 + FILTER_LEN cycles of C (±1 for synchronizer metastability).
- Stop-bit edge detected in cycle t: VALID=1 and the ERR pulse (if any) occur in cycle t+1.
- Throughput: one code per frame. The consumer must accept within one PS/2 frame time (about 11 × 60 µs) to avoid overflow.
- READY is a don't-care while VALID=0. VALID never depends combinationally on READY.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is required (the data bits plus the parity bit must contain an odd number of 1s). Failure discards the byte and pulses ERR.
- PS2_PARITY_CHECK_EN undefined: the parity bit is clocked through and ignored. Only start, stop, timeout and overflow errors exist.

## Test plan
- Reset with FILTER_LEN=4: send frame 0x1C (parity 0, stop 1), READY=1. Required: CODE=8'h1C, EXT=0, BRK=0, one-cycle VALID pulse, ERR never high.
- Send 0xE0, then 0xF0, then 0x74 with READY=1. Required: exactly one VALID, with CODE=8'h74, EXT=1, BRK=1. A following 0x1C gives EXT=0, BRK=0.
- With the macro defined, send 0x1C with parity bit 1. Required: no VALID, one ERR pulse. Without the macro, the same frame yields CODE=8'h1C.
- Hold READY=0 and send 0x1C, then 0x32. Required: VALID stays 1 with CODE=8'h1C and ERR pulses at the second stop bit. After raising READY, VALID drops and 0x32 is never presented.
- Send start plus 4 data bits, stop PS2C for TIMEOUT cycles, then send a full 0x29 frame. Required: one ERR pulse at timeout, then CODE=8'h29 valid.
- Inject PS2C glitches of FILTER_LEN-1 cycles mid-frame, and separately assert RST_N=0 mid-frame. Required: glitches produce no extra bits; reset clears all outputs, and the next clean 0x1C frame is received correctly.
